// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared types and helpers for the FFT output reorder buffer.
//               - bank_state_e : life cycle of one ping-pong bank
//               - cplx_t       : complex sample (CPLX_W-wide real/imag)
//               - bitrev       : bit reversal over a run-time bit count
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  // Widest address the reorder buffer supports (N = 4096).
  localparam int unsigned BR_W   = 12;
  // Component width of the shared complex sample view.
  localparam int unsigned CPLX_W = 32;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  typedef struct packed {
    logic [CPLX_W-1:0] re;
    logic [CPLX_W-1:0] im;
  } cplx_t;

  // Reverse the low 'bits' bits of v: reverse all BR_W bits, then shift the
  // result down so the reversed field lands at bit 0.
  function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] v,
                                             input int unsigned     bits);
    logic [BR_W-1:0] r;
    for (int i = 0; i < BR_W; i++) begin
      r[i] = v[BR_W-1-i];
    end
    return r >> (BR_W - bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder_bank.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_bank
// Description : One reorder bank: N words, two write ports, one synchronous
//               read port. Contents are never reset.
// Ports       : clock_i            - clock
//               wr0_* / wr1_*      - write enables, addresses and data
//               rd_en_i, rd_addr_i - read request; data appears next cycle
//               rd_data_o          - registered read data, held when idle
// Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int unsigned N  = 512,
  parameter int unsigned DW = 64
) (
  input  logic                 clock_i,
  input  logic                 wr0_en_i,
  input  logic [$clog2(N)-1:0] wr0_addr_i,
  input  logic [DW-1:0]        wr0_data_i,
  input  logic                 wr1_en_i,
  input  logic [$clog2(N)-1:0] wr1_addr_i,
  input  logic [DW-1:0]        wr1_data_i,
  input  logic                 rd_en_i,
  input  logic [$clog2(N)-1:0] rd_addr_i,
  output logic [DW-1:0]        rd_data_o
);

  logic [DW-1:0] mem_q [N];
  logic [DW-1:0] rd_data_q;

  // The two write addresses of a pair always differ (they differ in the
  // top address bit), so the two ports never collide.
  always_ff @(posedge clock_i) begin
    if (wr0_en_i) mem_q[wr0_addr_i] <= wr0_data_i;
    if (wr1_en_i) mem_q[wr1_addr_i] <= wr1_data_i;
    if (rd_en_i)  rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fft_reorder.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder
// Description : Converts the bit-reversed pair stream of an MDC FFT into a
//               natural-order sample stream using two ping-pong banks.
//               Optional feature macro: FFT_REORDER_OVF_EN adds the sticky
//               io_overflow frame-drop flag.
// Ports       : clock, reset (async, active low)
//               io_in1_*/io_in2_*, io_in_valid : input pair, no backpressure
//               io_out_*, io_out_valid/ready   : natural-order output stream
//               io_out_last                    : marks index N-1
//               io_overflow                    : sticky drop flag (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N = 512,
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] io_in1_real,
  input  logic [W-1:0] io_in1_imag,
  input  logic [W-1:0] io_in2_real,
  input  logic [W-1:0] io_in2_imag,
  input  logic         io_in_valid,
  output logic [W-1:0] io_out_real,
  output logic [W-1:0] io_out_imag,
  output logic         io_out_valid,
  input  logic         io_out_ready,
`ifdef FFT_REORDER_OVF_EN
  output logic         io_overflow,
`endif
  output logic         io_out_last
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = AW - 1;
  localparam logic [CW-1:0] LAST_PAIR = '1;
  localparam logic [AW-1:0] LAST_IDX  = '1;
  localparam logic [CW-1:0] C_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] A_ONE     = {{(AW-1){1'b0}}, 1'b1};

  // Bank bookkeeping
  bank_state_e st_q [2];
  bank_state_e st_d [2];
  logic        fill_bank_q, fill_bank_d;    // preferred bank for next frame
  logic        full_first_q, full_first_d;  // older of the FULL banks

  // Write side
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          drop_q, drop_d;

  // Read side
  logic          rd_active_q, rd_active_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          out_bank_q, out_bank_d;

  logic          w_we;
  logic          w_we_bank;
  logic [AW-1:0] w_wa0;
  logic [AW-1:0] w_wa1;
  logic          w_adv;
  logic          w_rd_have;
  logic          w_rd_bank;
  logic [AW-1:0] w_rd_addr;
  logic          w_re;
  logic [2*W-1:0] w_rdata [2];
  logic [2*W-1:0] w_rsel;

  // Pair c holds X[bitrev(2c)] and X[bitrev(2c+1)].
  assign w_wa0 = AW'(bitrev(BR_W'({wr_cnt_q, 1'b0}), AW));
  assign w_wa1 = AW'(bitrev(BR_W'({wr_cnt_q, 1'b1}), AW));

  // The output register stage advances when it is empty or being consumed.
  assign w_adv = ~out_valid_q | io_out_ready;

  always_comb begin
    st_d[0]      = st_q[0];
    st_d[1]      = st_q[1];
    fill_bank_d  = fill_bank_q;
    full_first_d = full_first_q;
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    drop_d       = drop_q;
    rd_active_d  = rd_active_q;
    rd_bank_d    = rd_bank_q;
    rd_cnt_d     = rd_cnt_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_bank_d   = out_bank_q;
    w_we         = 1'b0;
    w_we_bank    = wr_bank_q;
    w_rd_have    = 1'b0;
    w_rd_bank    = rd_bank_q;
    w_rd_addr    = rd_cnt_q;
    w_re         = 1'b0;

    // ---------------- write side ----------------
    if (io_in_valid) begin
      wr_cnt_d = wr_cnt_q + C_ONE;
      if (wr_cnt_q == '0) begin
        // Frame start: claim an EMPTY bank or drop the whole frame.
        if (st_q[fill_bank_q] == BANK_EMPTY) begin
          w_we                = 1'b1;
          w_we_bank           = fill_bank_q;
          wr_bank_d           = fill_bank_q;
          drop_d              = 1'b0;
          st_d[fill_bank_q]   = BANK_FILLING;
        end else if (st_q[~fill_bank_q] == BANK_EMPTY) begin
          w_we                = 1'b1;
          w_we_bank           = ~fill_bank_q;
          wr_bank_d           = ~fill_bank_q;
          drop_d              = 1'b0;
          st_d[~fill_bank_q]  = BANK_FILLING;
        end else begin
          drop_d              = 1'b1;
        end
      end else if (!drop_q) begin
        w_we = 1'b1;
        if (wr_cnt_q == LAST_PAIR) begin
          st_d[wr_bank_q] = BANK_FULL;
          fill_bank_d     = ~wr_bank_q;
          // Only becomes the oldest if the other bank is not already waiting.
          if (st_q[~wr_bank_q] != BANK_FULL) full_first_d = wr_bank_q;
        end
      end
    end

    // ---------------- read side ----------------
    if (rd_active_q) begin
      w_rd_have = 1'b1;
    end else if (st_q[full_first_q] == BANK_FULL) begin
      w_rd_have = 1'b1;
      w_rd_bank = full_first_q;
      w_rd_addr = '0;
    end else if (st_q[~full_first_q] == BANK_FULL) begin
      w_rd_have = 1'b1;
      w_rd_bank = ~full_first_q;
      w_rd_addr = '0;
    end

    if (w_adv) begin
      out_valid_d = w_rd_have;
      out_last_d  = w_rd_have && (w_rd_addr == LAST_IDX);
      if (w_rd_have) begin
        w_re        = 1'b1;
        out_bank_d  = w_rd_bank;
        rd_bank_d   = w_rd_bank;
        rd_cnt_d    = w_rd_addr + A_ONE;
        // Reads end after N-1 is issued so the next FULL bank can follow
        // immediately, while this bank stays DRAINING until N-1 is taken.
        rd_active_d = (w_rd_addr != LAST_IDX);
        if (!rd_active_q) st_d[w_rd_bank] = BANK_DRAINING;
      end
    end

    if (out_valid_q && io_out_ready && out_last_q) begin
      st_d[out_bank_q] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q[0]      <= BANK_EMPTY;
      st_q[1]      <= BANK_EMPTY;
      fill_bank_q  <= 1'b0;
      full_first_q <= 1'b0;
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      drop_q       <= 1'b0;
      rd_active_q  <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_bank_q   <= 1'b0;
    end else begin
      st_q[0]      <= st_d[0];
      st_q[1]      <= st_d[1];
      fill_bank_q  <= fill_bank_d;
      full_first_q <= full_first_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      drop_q       <= drop_d;
      rd_active_q  <= rd_active_d;
      rd_bank_q    <= rd_bank_d;
      rd_cnt_q     <= rd_cnt_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_bank_q   <= out_bank_d;
    end
  end

`ifdef FFT_REORDER_OVF_EN
  logic ovf_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (io_in_valid && (wr_cnt_q == '0) && drop_d) begin
      ovf_q <= 1'b1;
    end
  end
  assign io_overflow = ovf_q;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .N  (N),
      .DW (2*W)
    ) u_bank (
      .clock_i    (clock),
      .wr0_en_i   (w_we && (w_we_bank == 1'(b))),
      .wr0_addr_i (w_wa0),
      .wr0_data_i ({io_in1_real, io_in1_imag}),
      .wr1_en_i   (w_we && (w_we_bank == 1'(b))),
      .wr1_addr_i (w_wa1),
      .wr1_data_i ({io_in2_real, io_in2_imag}),
      .rd_en_i    (w_re && (w_rd_bank == 1'(b))),
      .rd_addr_i  (w_rd_addr),
      .rd_data_o  (w_rdata[b])
    );
  end

  // RAM read data is not reset, so the data outputs are forced to zero
  // whenever no sample is being presented.
  assign w_rsel       = w_rdata[out_bank_q];
  assign io_out_valid = out_valid_q;
  assign io_out_last  = out_last_q;
  assign io_out_real  = out_valid_q ? w_rsel[2*W-1:W] : '0;
  assign io_out_imag  = out_valid_q ? w_rsel[W-1:0]   : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_reorder
// Description : Scoreboard bench for fft_reorder (N=512, W=32). Each frame
//               carries sample value {tag, index} / ~{tag, index}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_reorder;
  import fft_pkg::*;

  localparam int N    = 512;
  localparam int W    = 32;
  localparam int LOGN = 9;

  typedef struct {
    cplx_t d;
    logic  last;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] io_in1_real = '0;
  logic [W-1:0] io_in1_imag = '0;
  logic [W-1:0] io_in2_real = '0;
  logic [W-1:0] io_in2_imag = '0;
  logic         io_in_valid = 1'b0;
  logic [W-1:0] io_out_real;
  logic [W-1:0] io_out_imag;
  logic         io_out_valid;
  logic         io_out_ready = 1'b1;
  logic         io_out_last;
`ifdef FFT_REORDER_OVF_EN
  logic         io_overflow;
`endif

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   rdy_mode = 0;   // 0 = ready high, 1 = ready low, 2 = random
  int   run_len = 0;
  int   max_run = 0;

  fft_reorder #(.N(N), .W(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in1_real  (io_in1_real),
    .io_in1_imag  (io_in1_imag),
    .io_in2_real  (io_in2_real),
    .io_in2_imag  (io_in2_imag),
    .io_in_valid  (io_in_valid),
    .io_out_real  (io_out_real),
    .io_out_imag  (io_out_imag),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
`ifdef FFT_REORDER_OVF_EN
    .io_overflow  (io_overflow),
`endif
    .io_out_last  (io_out_last)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached with %0d expected samples pending", q.size());
    $fatal(1, "watchdog expired");
  end

  function automatic int tb_bitrev(input int v);
    int r;
    r = 0;
    for (int k = 0; k < LOGN; k++) begin
      if (((v >> k) & 1) != 0) r = r | (1 << (LOGN - 1 - k));
    end
    return r;
  endfunction

  function automatic cplx_t sample(input logic [15:0] tag, input int idx);
    cplx_t s;
    s.re = {tag, 16'(idx)};
    s.im = ~s.re;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive_pair(input cplx_t a, input cplx_t b);
    io_in1_real = a.re;
    io_in1_imag = a.im;
    io_in2_real = b.re;
    io_in2_imag = b.im;
    io_in_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Sends npairs pairs of a frame; when keep is set the whole natural-order
  // frame is expected at the output.
  task automatic send_frame(input logic [15:0] tag, input int npairs,
                            input bit gaps, input bit keep);
    exp_t e;
    if (keep) begin
      for (int i = 0; i < N; i++) begin
        e.d    = sample(tag, i);
        e.last = (i == N - 1);
        q.push_back(e);
      end
    end
    for (int c = 0; c < npairs; c++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          io_in_valid = 1'b0;
          io_in1_real = 32'hDEAD_BEEF;
          io_in2_real = 32'hBAD0_CAFE;
          @(posedge clock);
          #1;
        end
      end
      drive_pair(sample(tag, tb_bitrev(2 * c)), sample(tag, tb_bitrev(2 * c + 1)));
    end
    io_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while ((q.size() != 0 || io_out_valid) && k < bound) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("drain_pending", 64'(q.size()), 64'd0);
  endtask

  // Ready driver
  initial forever begin
    @(posedge clock);
    #1;
    case (rdy_mode)
      0:       io_out_ready = 1'b1;
      1:       io_out_ready = 1'b0;
      default: io_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every transfer and checks stall hold.
  initial begin
    exp_t  e;
    logic  ps;
    cplx_t pd;
    logic  pl;
    ps = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        ps      = 1'b0;
        run_len = 0;
      end else begin
        if (ps) begin
          check("stall_valid", 64'(io_out_valid), 64'd1);
          check("stall_data", {io_out_real, io_out_imag}, pd);
          check("stall_last", 64'(io_out_last), 64'(pl));
        end
        if (io_out_valid) begin
          run_len++;
          if (run_len > max_run) max_run = run_len;
        end else begin
          run_len = 0;
        end
        if (io_out_valid && io_out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got sample %h last %0d, expected no output",
                     {io_out_real, io_out_imag}, io_out_last);
          end else begin
            e = q.pop_front();
            check("out_data", {io_out_real, io_out_imag}, e.d);
            check("out_last", 64'(io_out_last), 64'(e.last));
          end
        end
        ps = io_out_valid && !io_out_ready;
        pd = {io_out_real, io_out_imag};
        pl = io_out_last;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 64'(io_out_valid), 64'd0);
    check("rst_real",  64'(io_out_real), 64'd0);
    check("rst_imag",  64'(io_out_imag), 64'd0);
    check("rst_last",  64'(io_out_last), 64'd0);
`ifdef FFT_REORDER_OVF_EN
    check("rst_ovf",   64'(io_overflow), 64'd0);
`endif
    reset = 1'b1;
    @(posedge clock);
    #1;

    // 1: single frame, first valid two cycles after the last pair's cycle
    rdy_mode = 0;
    send_frame(16'h0001, N / 2, 1'b0, 1'b1);
    @(negedge clock);
    check("lat_t1_valid", 64'(io_out_valid), 64'd0);
    @(negedge clock);
    check("lat_t2_valid", 64'(io_out_valid), 64'd1);
    wait_drain(2000);

    // 2: back-to-back frames, no gap across the frame boundary
    max_run = 0;
    send_frame(16'h0002, N / 2, 1'b0, 1'b1);
    send_frame(16'h0003, N / 2, 1'b0, 1'b1);
    wait_drain(3000);
    check("b2b_run", 64'(max_run), 64'd1024);

    // 3: random ready
    rdy_mode = 2;
    send_frame(16'h0004, N / 2, 1'b0, 1'b1);
    send_frame(16'h0005, N / 2, 1'b0, 1'b1);
    wait_drain(6000);
    rdy_mode = 0;
    @(posedge clock);
    #1;

    // 4: ready low while three frames arrive; the third finds no EMPTY bank
    rdy_mode = 1;
    @(posedge clock);
    #1;
    send_frame(16'h0011, N / 2, 1'b0, 1'b1);
    send_frame(16'h0012, N / 2, 1'b0, 1'b1);
    send_frame(16'h0013, N / 2, 1'b0, 1'b0);
    check("ovf_stalled_valid", 64'(io_out_valid), 64'd1);
`ifdef FFT_REORDER_OVF_EN
    check("ovf_flag", 64'(io_overflow), 64'd1);
`endif
    rdy_mode = 0;
    wait_drain(3000);

    // 5: reset at pair 100 of a fill while the previous frame drains
    send_frame(16'h0021, N / 2, 1'b0, 1'b1);
    send_frame(16'h0022, 100, 1'b0, 1'b0);
    check("pre_rst_valid", 64'(io_out_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("async_rst_valid", 64'(io_out_valid), 64'd0);
    check("async_rst_real",  64'(io_out_real), 64'd0);
    check("async_rst_imag",  64'(io_out_imag), 64'd0);
    check("async_rst_last",  64'(io_out_last), 64'd0);
`ifdef FFT_REORDER_OVF_EN
    check("async_rst_ovf",   64'(io_overflow), 64'd0);
`endif
    q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    send_frame(16'h0023, N / 2, 1'b0, 1'b1);
    wait_drain(2000);

    // 6: ~50% input gaps, same data as the gap-free frame of test 1
    send_frame(16'h0001, N / 2, 1'b1, 1'b1);
    wait_drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 SHALL have parameter N, default 512, FFT frame length in points (power of two, 8..4096).
REQ-002 SHALL have parameter W, default 32, width of each real/imag component.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port io_in1_real / io_in1_imag  input  W each  first MDC output sample of the pair.
REQ-006 SHALL have port io_in2_real / io_in2_imag  input  W each  second MDC output sample of the pair.
REQ-007 SHALL have port io_in_valid  input  1  pair valid; there is no backpressure, so the pair is accepted or dropped in that cycle.
REQ-008 SHALL have port io_out_real / io_out_imag  output  W each  natural-order output sample.
REQ-009 SHALL have port io_out_valid  output  1  output sample valid.
REQ-010 SHALL have port io_out_ready  input  1  downstream accepts the sample; transfer occurs when valid and ready are both high.
REQ-011 SHALL have port io_out_last  output  1  high with the sample of index N-1.
REQ-012 SHALL have port io_overflow  output  1  sticky frame-drop flag; present only with FFT_REORDER_OVF_EN.

Function
REQ-013 SHALL treat the pair accepted at write count c (0..N/2-1) as in1 = X[bitrev(2c)] and in2 = X[bitrev(2c+1)], where bitrev is over log2(N) bits.
REQ-014 SHALL write both samples of a pair in the same cycle to one bank at their bit-reversed addresses, so two write ports per bank are needed.
REQ-015 SHALL use two banks (ping-pong), each holding N complex words; each bank has the states EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
REQ-016 SHALL move a bank EMPTY->FILLING on the first valid pair of a frame, and FILLING->FULL on pair N/2-1.
REQ-017 SHALL move a bank FULL->DRAINING when the read side is idle, taking the older bank first, and DRAINING->EMPTY on transfer of index N-1.
REQ-018 SHALL emit indices 0..N-1 in order, one per transfer, and hold io_out_real, io_out_imag and io_out_last stable while valid is high and ready is low.
REQ-019 SHALL assert io_out_valid for index 0 exactly 2 cycles after the cycle that writes pair N/2-1, provided the read side was idle.
REQ-020 SHALL sustain one transfer per cycle with io_out_ready held high: no bubbles inside a frame, and no bubble between back-to-back FULL banks.
REQ-021 SHALL allow a bank to fill while the other drains, since a bank only accepts writes when EMPTY.
REQ-022 SHALL drop a frame whose first pair arrives with no EMPTY bank: all N/2 pairs are discarded and nothing is written.
REQ-023 SHALL count only valid cycles toward a frame; gaps in io_in_valid are allowed.
REQ-024 SHALL NOT modify data; the output is bit-exact with the input.

Reset
REQ-025 SHALL, on reset low, immediately clear io_out_valid, io_out_last and io_overflow, and drive io_out_real and io_out_imag to 0.
REQ-026 SHALL, on reset, set both banks EMPTY, clear the write and read counters, and select bank 0 as the next fill bank; RAM contents are not reset.
REQ-027 SHALL discard any partial frame or drain interrupted by reset; the first valid pair after reset release is c = 0.

Configuration
REQ-028 SHALL, with FFT_REORDER_OVF_EN defined, have io_overflow go high the cycle after a dropped-frame start and stay high until reset.
REQ-029 SHALL, without FFT_REORDER_OVF_EN, have no io_overflow port and drop overflowing frames silently; all other behaviour is identical.

Structure
REQ-030 SHALL place the bank-state enum, the bitrev function and the complex-sample struct typedef (W-wide real/imag) in package fft_pkg.
REQ-031 SHALL implement storage as one sub-module fft_reorder_bank (N words, 2 write ports, 1 synchronous read port), instantiated twice.

Verification
REQ-032 SHALL check: one frame, N=512, sample value = its natural index (pair c=0 carries 0 and 256, c=1 carries 128 and 384) -> outputs 0..511 in order, last only on 511, first valid at T+2.
REQ-033 SHALL check: two back-to-back frames with ready always high -> 1024 consecutive valid cycles with no gap.
REQ-034 SHALL check: ready toggling 1-0 with a random pattern -> no sample lost or duplicated, and outputs stable while stalled.
REQ-035 SHALL check: ready low while three frames arrive -> frames 1 and 2 are kept, frame 3 is dropped, io_overflow=1 (with macro), and frames 1 and 2 drain intact.
REQ-036 SHALL check: reset asserted at pair 100 of a fill and mid-drain -> outputs are 0 and valid is 0 at once, and a fresh frame after release is correct.
REQ-037 SHALL check: 50% random io_in_valid gaps -> output is identical to the gap-free run.
